// File: rtl/tpu_host_bridge.sv
// tpu_host_bridge: Avalon-MM host slave that forwards single accesses to a TPU core,
// stalling the host while a MAC operation runs and returning reads two cycles after accept.
module tpu_host_bridge #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16,
    parameter int DIM   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADDRW-1:0] avm_address,
    input  logic             avm_read,
    input  logic             avm_write,
    input  logic [DATAW-1:0] avm_writedata,
    output logic             avm_waitrequest,
    output logic [DATAW-1:0] avm_readdata,
    output logic             avm_readdatavalid,
    output logic [ADDRW-1:0] tpu_addr,
    output logic             tpu_r_w,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);
    localparam int BUSY = 3 * DIM - 1;
    localparam int CW   = $clog2(BUSY + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, MAC_WAIT} state_t;
    state_t           state, state_nxt;
    logic             ready;
    logic [ADDRW-1:0] addr_q;
    logic [DATAW-1:0] data_q;
    logic             wr_q, rd_q;
    logic [CW-1:0]    busy_cnt;
    logic [31:0]      mac_cnt;
    logic             accept, w_map, r_c, mac_hit, busy_done;
    logic [DATAW-1:0] rd_data;
    // ready holds off the host until the first edge after reset release
    assign accept    = state == IDLE && ready && (avm_read || avm_write);
    assign r_c       = addr_q >= ADDRW'(16'h0300) && addr_q <= ADDRW'(16'h037F);
    assign mac_hit   = wr_q && addr_q == ADDRW'(16'h0400);
    assign w_map     = (addr_q >= ADDRW'(16'h0100) && addr_q <= ADDRW'(16'h013F)) ||
                       (addr_q >= ADDRW'(16'h0200) && addr_q <= ADDRW'(16'h023F)) ||
                       r_c || addr_q == ADDRW'(16'h0400);
    assign busy_done = busy_cnt == CW'(BUSY - 1);
    assign rd_data   = r_c ? tpu_dataOut : addr_q == ADDRW'(16'h0500) ? DATAW'(mac_cnt) : '0;
    always_comb begin
        state_nxt       = state;
        avm_waitrequest = !ready || state != IDLE;
        tpu_addr        = '0;
        tpu_r_w         = 1'b0;
        tpu_dataIn      = '0;
        state_nxt       = state == IDLE  ? (accept ? ISSUE : IDLE) :
                          state == ISSUE ? (mac_hit ? MAC_WAIT : IDLE) :
                          busy_done      ? IDLE : MAC_WAIT;
        if (state == ISSUE) begin
            tpu_addr   = addr_q;
            tpu_r_w    = wr_q && w_map;
            tpu_dataIn = data_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ready             <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            wr_q              <= 1'b0;
            rd_q              <= 1'b0;
            busy_cnt          <= '0;
            mac_cnt           <= '0;
            avm_readdatavalid <= 1'b0;
            avm_readdata      <= '0;
        end else begin
            state <= state_nxt;
            ready <= 1'b1;
            if (accept) begin
                addr_q <= avm_address;
                data_q <= avm_writedata;
                wr_q   <= avm_write;
                rd_q   <= avm_read && !avm_write;
            end
            busy_cnt <= (state == MAC_WAIT && !busy_done) ? busy_cnt + 1'b1 : '0;
            if (state == MAC_WAIT && busy_done) mac_cnt <= mac_cnt + 1'b1;
            avm_readdatavalid <= state == ISSUE && rd_q;
            if (state == ISSUE && rd_q) avm_readdata <= rd_data;
        end
    end
endmodule

// File: tb/tb_tpu_host_bridge.sv
// tb_tpu_host_bridge: directed checks of the TPU host bridge; the TPU core is modelled as
// returning a tag built from the address it is given.
module tb_tpu_host_bridge;
    logic        clk = 0, rst_n = 0;
    logic [15:0] avm_address = 0;
    logic        avm_read = 0, avm_write = 0;
    logic [63:0] avm_writedata = 0;
    logic        avm_waitrequest, avm_readdatavalid, tpu_r_w;
    logic [63:0] avm_readdata, tpu_dataIn, tpu_dataOut;
    logic [15:0] tpu_addr;
    int checks = 0, errors = 0;

    assign tpu_dataOut = {16'hC0DE, 32'h0, tpu_addr};

    tpu_host_bridge #(.DATAW(64), .ADDRW(16), .DIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .tpu_addr(tpu_addr),
        .tpu_r_w(tpu_r_w), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait until accepted; returns in the ISSUE cycle.
    task automatic send(input logic [15:0] a, input logic [63:0] d, input logic rd, input logic wr,
                        output int stalls);
        avm_address = a; avm_writedata = d; avm_read = rd; avm_write = wr;
        stalls = 0;
        while (avm_waitrequest && stalls < 100) begin
            stalls++;
            cycle();
        end
        checks++;
        if (avm_waitrequest) begin
            errors++;
            $display("FAIL accept_timeout addr %h still stalled after %0d cycles", a, stalls);
        end
        cycle();
        avm_read = 0; avm_write = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (avm_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got %b exp 1", avm_waitrequest); end
        checks++; if (avm_readdatavalid !== 1'b0 || avm_readdata !== 64'h0) begin errors++; $display("FAIL rst_read got %b %h exp 0 0", avm_readdatavalid, avm_readdata); end
        checks++; if (tpu_addr !== 16'h0 || tpu_r_w !== 1'b0 || tpu_dataIn !== 64'h0) begin errors++; $display("FAIL rst_tpu got %h %b %h exp 0", tpu_addr, tpu_r_w, tpu_dataIn); end
        repeat (3) cycle();
        rst_n = 1;
        #1;
        checks++; if (avm_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_release_waitreq got %b exp 1", avm_waitrequest); end
        cycle();
        checks++; if (avm_waitrequest !== 1'b0) begin errors++; $display("FAIL first_edge_waitreq got %b exp 0", avm_waitrequest); end
    endtask

    task automatic test_write_a();
        int s;
        send(16'h0100, 64'h0102030405060708, 0, 1, s);
        checks++; if (tpu_addr !== 16'h0100 || tpu_r_w !== 1'b1 || tpu_dataIn !== 64'h0102030405060708) begin errors++; $display("FAIL write_a_issue got %h %b %h exp 0100 1 0102030405060708", tpu_addr, tpu_r_w, tpu_dataIn); end
        checks++; if (avm_waitrequest !== 1'b1) begin errors++; $display("FAIL write_a_waitreq got %b exp 1", avm_waitrequest); end
        cycle();
        checks++; if (tpu_addr !== 16'h0 || tpu_r_w !== 1'b0 || tpu_dataIn !== 64'h0 || avm_waitrequest !== 1'b0) begin errors++; $display("FAIL write_a_after got %h %b %h %b exp 0 0 0 0", tpu_addr, tpu_r_w, tpu_dataIn, avm_waitrequest); end
        checks++; if (avm_readdatavalid !== 1'b0) begin errors++; $display("FAIL write_a_rvalid got %b exp 0", avm_readdatavalid); end
    endtask

    task automatic test_unmapped_write();
        int s;
        send(16'h0700, 64'hFFFF, 0, 1, s);
        checks++; if (tpu_r_w !== 1'b0 || tpu_addr !== 16'h0700) begin errors++; $display("FAIL unmapped_issue got %h %b exp 0700 0", tpu_addr, tpu_r_w); end
        cycle();
        checks++; if (avm_waitrequest !== 1'b0) begin errors++; $display("FAIL unmapped_idle got waitreq %b exp 0", avm_waitrequest); end
    endtask

    task automatic test_mac_then_read();
        int s;
        logic rw_seen;
        send(16'h0400, 64'h1, 0, 1, s);
        checks++; if (tpu_r_w !== 1'b1 || tpu_addr !== 16'h0400) begin errors++; $display("FAIL mac_issue got %h %b exp 0400 1", tpu_addr, tpu_r_w); end
        avm_address = 16'h0300; avm_read = 1;
        s = 0; rw_seen = 0;
        while (avm_waitrequest && s < 100) begin
            s++;
            cycle();
            if (avm_waitrequest && tpu_r_w) rw_seen = 1;
        end
        checks++; if (s !== 24) begin errors++; $display("FAIL mac_stall got %0d cycles exp 24", s); end
        checks++; if (rw_seen !== 1'b0) begin errors++; $display("FAIL mac_wait_rw got %b exp 0", rw_seen); end
        cycle();
        avm_read = 0;
        checks++; if (tpu_addr !== 16'h0300 || tpu_r_w !== 1'b0) begin errors++; $display("FAIL c_read_issue got %h %b exp 0300 0", tpu_addr, tpu_r_w); end
        checks++; if (avm_readdatavalid !== 1'b0) begin errors++; $display("FAIL c_read_early got %b exp 0", avm_readdatavalid); end
        cycle();
        checks++; if (avm_readdatavalid !== 1'b1 || avm_readdata !== 64'hC0DE000000000300) begin errors++; $display("FAIL c_read_data got %b %h exp 1 c0de000000000300", avm_readdatavalid, avm_readdata); end
        cycle();
        checks++; if (avm_readdatavalid !== 1'b0 || avm_readdata !== 64'hC0DE000000000300) begin errors++; $display("FAIL c_read_hold got %b %h exp 0 c0de000000000300", avm_readdatavalid, avm_readdata); end
    endtask

    task automatic test_mac_count();
        int s;
        repeat (2) begin
            send(16'h0400, 64'h0, 0, 1, s);
            repeat (24) cycle();
        end
        checks++; if (avm_waitrequest !== 1'b0) begin errors++; $display("FAIL mac_done_idle got waitreq %b exp 0", avm_waitrequest); end
        send(16'h0500, 64'h0, 1, 0, s);
        cycle();
        checks++; if (avm_readdatavalid !== 1'b1 || avm_readdata !== 64'd3) begin errors++; $display("FAIL mac_count got %b %h exp 1 3", avm_readdatavalid, avm_readdata); end
        cycle();
        send(16'h0600, 64'h0, 1, 0, s);
        cycle();
        checks++; if (avm_readdatavalid !== 1'b1 || avm_readdata !== 64'd0) begin errors++; $display("FAIL unmapped_read got %b %h exp 1 0", avm_readdatavalid, avm_readdata); end
        cycle();
    endtask

    task automatic test_read_write_both();
        int s;
        send(16'h0200, 64'hA5A5A5A5_5A5A5A5A, 1, 1, s);
        checks++; if (tpu_addr !== 16'h0200 || tpu_r_w !== 1'b1 || tpu_dataIn !== 64'hA5A5A5A55A5A5A5A) begin errors++; $display("FAIL rw_issue got %h %b %h exp 0200 1 a5a5a5a55a5a5a5a", tpu_addr, tpu_r_w, tpu_dataIn); end
        cycle();
        checks++; if (avm_readdatavalid !== 1'b0 || tpu_r_w !== 1'b0) begin errors++; $display("FAIL rw_no_rvalid got %b %b exp 0 0", avm_readdatavalid, tpu_r_w); end
        cycle();
        checks++; if (avm_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rvalid_late got %b exp 0", avm_readdatavalid); end
    endtask

    task automatic test_reset_mid_read();
        int s;
        logic seen;
        send(16'h0500, 64'h0, 1, 0, s);
        cycle();
        checks++; if (avm_readdata !== 64'd3) begin errors++; $display("FAIL pre_reset_count got %h exp 3", avm_readdata); end
        send(16'h0310, 64'h0, 1, 0, s);
        rst_n = 0;
        #1;
        checks++; if (avm_waitrequest !== 1'b1 || avm_readdatavalid !== 1'b0 || avm_readdata !== 64'h0) begin errors++; $display("FAIL mid_rst_avm got %b %b %h exp 1 0 0", avm_waitrequest, avm_readdatavalid, avm_readdata); end
        checks++; if (tpu_addr !== 16'h0 || tpu_r_w !== 1'b0 || tpu_dataIn !== 64'h0) begin errors++; $display("FAIL mid_rst_tpu got %h %b %h exp 0 0 0", tpu_addr, tpu_r_w, tpu_dataIn); end
        seen = 0;
        repeat (2) begin cycle(); if (avm_readdatavalid) seen = 1; end
        rst_n = 1;
        repeat (3) begin cycle(); if (avm_readdatavalid) seen = 1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid got %b exp 0", seen); end
        send(16'h0500, 64'h0, 1, 0, s);
        cycle();
        checks++; if (avm_readdatavalid !== 1'b1 || avm_readdata !== 64'd0) begin errors++; $display("FAIL post_rst_count got %b %h exp 1 0", avm_readdatavalid, avm_readdata); end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_unmapped_write();
        test_mac_then_read();
        test_mac_count();
        test_read_write_both();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_host_bridge.md
TPU_HOST_BRIDGE -- requirements
Module: tpu_host_bridge

Interface
REQ-001 SHALL have parameter DATAW, default 64, host/TPU data width.
REQ-002 SHALL have parameter ADDRW, default 16, host/TPU address width.
REQ-003 SHALL have parameter DIM, default 8, systolic dimension; MAC busy window = 3*DIM-1 cycles.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port avm_address, input, ADDRW, host byte address.
REQ-007 SHALL have ports avm_read and avm_write, input, 1 each, host request strobes.
REQ-008 SHALL have port avm_writedata, input, DATAW, host write data.
REQ-009 SHALL have port avm_waitrequest, output, 1, stall; a request is accepted in a cycle where it is asserted and waitrequest=0.
REQ-010 SHALL have ports avm_readdata, output, DATAW, and avm_readdatavalid, output, 1, the read response.
REQ-011 SHALL have ports tpu_addr, output, ADDRW; tpu_r_w, output, 1 (1=write); tpu_dataIn, output, DATAW; tpu_dataOut, input, DATAW; these drive the TPU core.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, MAC_WAIT.
REQ-013 IDLE: waitrequest=0; on accept, register address/data/type and go to ISSUE.
REQ-014 ISSUE, exactly 1 cycle: waitrequest=1; drive tpu_addr=registered address; tpu_r_w=1 only for a write to a mapped write address; tpu_dataIn=registered data.
REQ-015 ISSUE exit: to MAC_WAIT if the access was a write to 0x0400, else to IDLE.
REQ-016 MAC_WAIT: waitrequest=1 for exactly 3*DIM-1 cycles (23 at DIM=8), counted by an internal counter; tpu_r_w=0; then to IDLE.
REQ-017 Outside ISSUE: tpu_addr=0, tpu_r_w=0, tpu_dataIn=0.
REQ-018 Write map: A 0x0100-0x013F, B 0x0200-0x023F, C 0x0300-0x037F, MAC trigger 0x0400; any other write address is accepted and dropped, with tpu_r_w=0 in ISSUE.
REQ-019 Read map: C 0x0300-0x037F returns tpu_dataOut sampled at the end of ISSUE; 0x0500 returns the MAC-done counter, zero-extended; all other addresses return 0.
REQ-020 Read latency: accepted in cycle N, avm_readdatavalid=1 for exactly cycle N+2, with avm_readdata valid in that cycle; avm_readdata SHALL hold its value otherwise.
REQ-021 Throughput is at most one access per 2 cycles; back-to-back requests are held off by waitrequest in ISSUE.
REQ-022 If read and write are asserted together, the bridge SHALL perform the write only; no readdatavalid is generated.
REQ-023 MAC-done counter: 32-bit; increments by 1 in the last MAC_WAIT cycle; wraps 0xFFFFFFFF->0.
REQ-024 Requests during MAC_WAIT SHALL be stalled, not dropped; the host must hold them until accepted.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, avm_waitrequest=1, avm_readdatavalid=0, avm_readdata=0, tpu_addr=0, tpu_r_w=0, tpu_dataIn=0, MAC counter=0, busy counter=0.
REQ-026 avm_waitrequest SHALL deassert in the first clk edge after rst_n rises.
REQ-027 Reset mid-ISSUE or mid-MAC_WAIT SHALL abort; a pending read response SHALL never be emitted.

Verification
REQ-028 Write 0x0100 data 0x0102030405060708 -> next cycle tpu_addr=0x0100, tpu_r_w=1 one cycle, tpu_dataIn=0x0102030405060708, waitrequest=1 that cycle.
REQ-029 Write 0x0400 then immediate read 0x0300 -> waitrequest high 24 cycles (ISSUE+23); read accepted afterwards; readdatavalid 2 cycles after accept, data=tpu_dataOut.
REQ-030 Read 0x0500 after three MAC triggers -> readdata=3; read 0x0600 -> readdata=0, readdatavalid=1.
REQ-031 Write to 0x0700 -> accepted, tpu_r_w stays 0, FSM returns to IDLE after 1 cycle.
REQ-032 read+write both high at 0x0200 -> one tpu write, no readdatavalid.
REQ-033 rst_n low in cycle N+1 of a read -> readdatavalid never asserts, all outputs at reset values, MAC counter=0.
